branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/sparc_pkg.sv | 24 ++
 rtl/branch_target_adder.sv | 23 ++
 rtl/branch_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/sparc_pkg.sv
// ============================================================================
// Module      : sparc_pkg
// Description : Shared types and constants for the SPARC branch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_pkg;

    localparam int WORD_W = 32;
    localparam int DISP_W = 22;

    localparam logic [3:0] COND_BA = 4'b1000;
    localparam logic [3:0] COND_BN = 4'b0000;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ANNUL  = 2'd2
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_target_adder.sv
// ============================================================================
// Module      : branch_target_adder
// Description : Bicc target = pc + sign_ext(disp22) * 4, modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_adder
    import sparc_pkg::*;
(
    input  logic [WORD_W-1:0] i_pc,
    input  logic [DISP_W-1:0] i_disp22,
    output logic [WORD_W-1:0] o_target
);

    logic [WORD_W-1:0] w_offset;

    assign w_offset = {{(WORD_W-DISP_W-2){i_disp22[DISP_W-1]}}, i_disp22, 2'b00};
    assign o_target = i_pc + w_offset;

endmodule

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
// Module      : branch_sequencer
// Description : PC/nPC sequencer with SPARC delay-slot and annul handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_sequencer
    import sparc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 instr_valid,
    input  logic                 is_bicc,
    input  logic                 annul_bit,
    input  logic [DISP_W-1:0]    disp22,
    input  logic                 cond_true,
    input  logic                 is_ba,
    input  logic                 is_bn,
    input  logic                 redirect,
    input  logic [WORD_W-1:0]    redirect_addr,
    output logic [WORD_W-1:0]    pc,
    output logic [WORD_W-1:0]    npc,
    output logic                 annul_out,
    output logic                 in_delay_slot
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_npc;
    logic [WORD_W-1:0] w_pc_nxt;
    logic [WORD_W-1:0] w_npc_nxt;
    logic [WORD_W-1:0] w_target;
    logic [WORD_W-1:0] w_npc_inc;
    logic              w_taken;

    branch_target_adder u_target (
        .i_pc     (r_pc),
        .i_disp22 (disp22),
        .o_target (w_target)
    );

    assign w_npc_inc = r_npc + 32'd4;
    // BN can never be taken and BA always is, whatever cond_true reports.
    assign w_taken   = (cond_true | is_ba) & ~is_bn;

    always_comb begin
        w_pc_nxt    = r_pc;
        w_npc_nxt   = r_npc;
        w_state_nxt = r_state;
        if (redirect) begin
            w_pc_nxt    = redirect_addr;
            w_npc_nxt   = redirect_addr + 32'd4;
            w_state_nxt = ST_NORMAL;
        end else if (!stall && instr_valid) begin
            w_pc_nxt    = r_npc;
            w_npc_nxt   = w_npc_inc;
            w_state_nxt = ST_NORMAL;
            // An annulled slot is never decoded, so its Bicc fields are ignored.
            if ((r_state != ST_ANNUL) && is_bicc) begin
                if (w_taken) begin
                    w_npc_nxt   = w_target;
                    w_state_nxt = (is_ba && annul_bit) ? ST_ANNUL : ST_DELAY;
                end else begin
                    w_state_nxt = annul_bit ? ST_ANNUL : ST_DELAY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + 32'd4;
            r_state <= ST_NORMAL;
        end else begin
            r_pc    <= w_pc_nxt;
            r_npc   <= w_npc_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign pc            = r_pc;
    assign npc           = r_npc;
    assign annul_out     = (r_state == ST_ANNUL);
    assign in_delay_slot = (r_state == ST_DELAY) || (r_state == ST_ANNUL);

endmodule

`default_nettype wire
